// File: rtl/periph_bridge.sv
// Single-master to NSLV-slave bridge: registers the request, decodes the address to one
// chip select, waits for slave ready or timeout, and returns a one-cycle response strobe.
module periph_bridge #(
  parameter int                 NSLV       = 4,
  parameter logic [NSLV*32-1:0] BASE_ADDRS = {32'h0000_8010, 32'h0000_8000, 32'h0000_7F00, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] ADDR_MASKS = {32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_8000},
  parameter int                 TIMEOUT    = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic [31:0]        addr_i,
  input  logic               wen_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         wmask_i,
  output logic [31:0]        rdata_o,
  output logic               done_o,
  output logic               err_o,
  output logic               busy_o,
  output logic [7:0]         err_cnt_o,
  output logic [NSLV-1:0]    s_csb_o,
  output logic               s_wen_o,
  output logic [31:0]        s_addr_o,
  output logic [31:0]        s_wdata_o,
  output logic [3:0]         s_wmask_o,
  input  logic [NSLV*32-1:0] s_rdata_i,
  input  logic [NSLV-1:0]    s_ready_i
);

  // state  | meaning
  // IDLE   | waiting for req_i, decode on acceptance
  // ACCESS | chip select asserted, waiting for ready or timeout
  // RESP   | one-cycle done_o strobe, then back to IDLE
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t          state_q, state_nxt;
  logic [SW-1:0]   sel_q;
  logic [CW-1:0]   cnt_q;
  logic            hit;
  logic [SW-1:0]   hit_idx;
  logic [NSLV-1:0] hit_oh;
  logic            sel_ready;
  logic [31:0]     sel_rdata;
  logic            tmo;
  logic [7:0]      err_cnt_inc;

  // Scan from the top index down so the lowest matching slave is the last to overwrite.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr_i & ADDR_MASKS[i*32 +: 32]) == (BASE_ADDRS[i*32 +: 32] & ADDR_MASKS[i*32 +: 32])) begin
        hit       = 1'b1;
        hit_idx   = SW'(i);
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == SW'(i)) begin
        sel_ready = s_ready_i[i];
        sel_rdata = s_rdata_i[i*32 +: 32];
      end
    end
  end

  assign tmo         = (TIMEOUT != 0) && (cnt_q == TMO_LAST);
  assign err_cnt_inc = (err_cnt_o == 8'hFF) ? 8'hFF : err_cnt_o + 8'd1;
  assign done_o      = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (req_i) state_nxt = hit ? ACCESS : RESP;
      ACCESS:  if (sel_ready || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s_csb_o   <= '1;
      s_wen_o   <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      s_wmask_o <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            s_wen_o   <= wen_i;
            s_addr_o  <= addr_i;
            s_wdata_o <= wdata_i;
            s_wmask_o <= wmask_i;
            sel_q     <= hit_idx;
            cnt_q     <= '0;
            if (hit) begin
              s_csb_o <= ~hit_oh;
            end else begin
              rdata_o   <= '0;
              err_o     <= 1'b1;
              err_cnt_o <= err_cnt_inc;
            end
          end
        end
        ACCESS: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (sel_ready) begin
            s_csb_o <= '1;
            rdata_o <= s_wen_o ? sel_rdata : 32'h0;
            err_o   <= 1'b0;
          end else if (tmo) begin
            s_csb_o   <= '1;
            rdata_o   <= '0;
            err_o     <= 1'b1;
            err_cnt_o <= err_cnt_inc;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/periph_bridge.md
PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 Parameter NSLV, default 4, number of slave channels, legal range 1..8.
REQ-002 Parameter BASE_ADDRS, default {32'h0000_8010, 32'h0000_8000, 32'h0000_7F00, 32'h0000_0000}, NSLV*32-bit flat vector; slice i is slave i base.
REQ-003 Parameter ADDR_MASKS, default {32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'hFFFF_8000}, NSLV*32-bit flat vector; slice i is slave i compare mask.
REQ-004 Parameter TIMEOUT, default 16, maximum ACCESS cycles before error; 0 disables timeout.
REQ-005 clk_i  input  1  single system clock, all logic on rising edge.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 req_i  input  1  core access request.
REQ-008 addr_i  input  32  byte address.
REQ-009 wen_i  input  1  0 = write, 1 = read.
REQ-010 wdata_i  input  32  write data.
REQ-011 wmask_i  input  4  byte write mask.
REQ-012 rdata_o  output  32  read response data.
REQ-013 done_o  output  1  one-cycle response strobe.
REQ-014 err_o  output  1  error qualifier, valid when done_o=1.
REQ-015 busy_o  output  1  bridge not idle; req_i ignored.
REQ-016 err_cnt_o  output  8  saturating error count.
REQ-017 s_csb_o  output  NSLV  per-slave chip select, active-low.
REQ-018 s_wen_o, s_addr_o, s_wdata_o, s_wmask_o  output  1/32/32/4  registered request copy broadcast to all slaves.
REQ-019 s_rdata_i  input  NSLV*32  per-slave read data, slice i for slave i.
REQ-020 s_ready_i  input  NSLV  per-slave completion, sampled only for the selected slave.

Function
REQ-021 States SHALL be IDLE, ACCESS, RESP; busy_o = (state != IDLE).
REQ-022 In IDLE with req_i=1 (cycle T): latch addr/wen/wdata/wmask into s_* registers, decode, and leave IDLE at T+1.
REQ-023 Slave i hits when (addr_i & MASK_i) == (BASE_i & MASK_i); on multiple hits the lowest index SHALL win.
REQ-024 Hit: enter ACCESS at T+1 with s_csb_o[i]=0, all other bits 1; s_csb_o held until exit from ACCESS.
REQ-025 No hit: enter RESP at T+1 directly, no s_csb_o asserted, err_o=1, rdata_o=0.
REQ-026 In ACCESS, s_ready_i[i]=1 SHALL move to RESP next cycle; for reads rdata_o captures s_rdata_i slice i in that same edge, for writes rdata_o=0; err_o=0.
REQ-027 Minimum hit latency: done_o at T+2 (ready in first ACCESS cycle); ready from non-selected slaves ignored.
REQ-028 Cycle counter increments each ACCESS cycle, cleared on entry; when TIMEOUT!=0 and count reaches TIMEOUT-1 without ready, move to RESP with err_o=1, rdata_o=0, s_csb_o all 1.
REQ-029 Ready and timeout in the same cycle: ready SHALL win (err_o=0).
REQ-030 RESP lasts exactly one cycle: done_o=1, then IDLE unconditionally; req_i in RESP ignored, so back-to-back accesses accepted every 3 cycles minimum.
REQ-031 err_cnt_o increments by 1 on every done_o with err_o=1, saturating at 8'hFF (no wrap).
REQ-032 rdata_o and err_o SHALL hold their value until the next RESP.
REQ-033 Counter width SHALL be clog2(TIMEOUT+1), minimum 1 bit.

Reset
REQ-034 reset_i=1 at a clock edge SHALL force state IDLE, s_csb_o all 1, done_o=0, err_o=0, rdata_o=0, err_cnt_o=0, s_* registers 0, counter 0.
REQ-035 Reset mid-ACCESS SHALL abort the access with no done_o pulse; a request sampled with reset_i=1 is discarded.

Verification
REQ-036 Read 0x0000_8004, slave 2 ready same cycle with data 0xDEAD_BEEF -> s_csb_o=4'b1011 at T+1, done_o=1 err_o=0 rdata_o=0xDEAD_BEEF at T+2.
REQ-037 Write 0x0000_0100 wdata 0x1234_5678 wmask 4'b0011 -> s_csb_o[0]=0, s_wen_o=0, s_wdata_o/s_wmask_o match, done_o with rdata_o=0.
REQ-038 Read 0x0001_0000 (unmapped) -> no s_csb_o, done_o=1 err_o=1 at T+1, err_cnt_o=1.
REQ-039 Slave never ready, TIMEOUT=16 -> 16 ACCESS cycles, done_o=1 err_o=1, s_csb_o all 1 in RESP; ready asserted on cycle 16 instead -> err_o=0.
REQ-040 300 unmapped accesses -> err_cnt_o=8'hFF, no wrap; reset -> 0.
REQ-041 reset_i pulsed during ACCESS -> no done_o, s_csb_o all 1 next cycle, req_i held high during reset ignored, accepted first cycle after reset deasserts.
